// File: rtl/ysyx_23060184_arbiter.sv
// Two-master (IFU/LSU) arbiter in front of a single SRAM port.
// Alternates ownership on contention, holds the grant for a whole transaction, and muxes SRAM responses back to the owner.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ACERR_WIDTH
`define ACERR_WIDTH 2
`endif
`ifndef NUM_ARB_MASTERS
`define NUM_ARB_MASTERS 2
`endif
`ifndef EMPTY_GRANT
`define EMPTY_GRANT 2'b00
`endif
`ifndef INSTMEM_GRANT
`define INSTMEM_GRANT 2'b01
`endif
`ifndef DATAMEM_GRANT
`define DATAMEM_GRANT 2'b10
`endif

module ysyx_23060184_arbiter #(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int ACERR_WIDTH = `ACERR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_arvalid,
  input  logic                        i_rready,
  input  logic                        d_arvalid,
  input  logic                        d_rready,
  input  logic                        d_awvalid,
  input  logic                        d_wvalid,
  input  logic                        d_bready,
  input  logic                        s_arready,
  input  logic [DATA_WIDTH-1:0]       s_rdata,
  input  logic [ACERR_WIDTH-1:0]      s_rresp,
  input  logic                        s_rvalid,
  input  logic                        s_awready,
  input  logic                        s_wready,
  input  logic [ACERR_WIDTH-1:0]      s_bresp,
  input  logic                        s_bvalid,
  output logic [`NUM_ARB_MASTERS-1:0] grant,
  output logic                        i_arready,
  output logic [DATA_WIDTH-1:0]       i_rdata,
  output logic [ACERR_WIDTH-1:0]      i_rresp,
  output logic                        i_rvalid,
  output logic                        d_arready,
  output logic [DATA_WIDTH-1:0]       d_rdata,
  output logic [ACERR_WIDTH-1:0]      d_rresp,
  output logic                        d_rvalid,
  output logic                        d_awready,
  output logic                        d_wready,
  output logic [ACERR_WIDTH-1:0]      d_bresp,
  output logic                        d_bvalid
);

  // State codes double as the grant encoding, so grant comes straight off the register.
  typedef enum logic [1:0] {
    IDLE  = `EMPTY_GRANT,
    GNT_I = `INSTMEM_GRANT,
    GNT_D = `DATAMEM_GRANT
  } state_t;

  state_t state_reg, state_next;
  logic   last_d_reg;
  logic   op_wr_reg;
  logic   i_req, d_req, i_done, d_done;

  assign i_req  = i_arvalid;
  assign d_req  = d_arvalid | d_awvalid;
  assign i_done = s_rvalid & i_rready;
  assign d_done = op_wr_reg ? (s_bvalid & d_bready) : (s_rvalid & d_rready);
  assign grant  = state_reg;

  // d_wvalid is handled by the SRAM directly; the arbiter only needs the write-address request.
  logic unused_ok;
  assign unused_ok = d_wvalid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      last_d_reg <= 1'b1;
      op_wr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && state_next == GNT_D) begin
        last_d_reg <= 1'b1;
        op_wr_reg  <= d_awvalid;
      end else if (state_reg == IDLE && state_next == GNT_I) begin
        last_d_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (i_req && d_req) state_next = last_d_reg ? GNT_I : GNT_D;
        else if (i_req)     state_next = GNT_I;
        else if (d_req)     state_next = GNT_D;
      end
      GNT_I:   if (i_done) state_next = IDLE;
      GNT_D:   if (d_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    i_arready = 1'b0;
    i_rdata   = '0;
    i_rresp   = '0;
    i_rvalid  = 1'b0;
    d_arready = 1'b0;
    d_rdata   = '0;
    d_rresp   = '0;
    d_rvalid  = 1'b0;
    d_awready = 1'b0;
    d_wready  = 1'b0;
    d_bresp   = '0;
    d_bvalid  = 1'b0;
    case (state_reg)
      GNT_I: begin
        i_arready = s_arready;
        i_rdata   = s_rdata;
        i_rresp   = s_rresp;
        i_rvalid  = s_rvalid;
      end
      GNT_D: begin
        d_arready = s_arready;
        d_rdata   = s_rdata;
        d_rresp   = s_rresp;
        d_rvalid  = s_rvalid;
        d_awready = s_awready;
        d_wready  = s_wready;
        d_bresp   = s_bresp;
        d_bvalid  = s_bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060184_arbiter.sv
// Directed scenarios plus a randomized run, all checked every cycle against an ownership model.
module tb_ysyx_23060184_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic        i_arvalid, i_rready, d_arvalid, d_rready, d_awvalid, d_wvalid, d_bready;
  logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  logic [1:0]  grant;
  logic        i_arready, i_rvalid, d_arready, d_rvalid, d_awready, d_wready, d_bvalid;
  logic [31:0] i_rdata, d_rdata;
  logic [1:0]  i_rresp, d_rresp, d_bresp;

  int checks = 0;
  int errors = 0;
  // Model: who owns the SRAM (0 none, 1 IFU, 2 LSU), who was served last, and the LSU op kind.
  int owner = 0;
  int last_served = 2;
  bit lsu_write = 1'b0;

  ysyx_23060184_arbiter dut (
    .clk(clk), .rstn(rstn),
    .i_arvalid(i_arvalid), .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_rready(d_rready), .d_awvalid(d_awvalid),
    .d_wvalid(d_wvalid), .d_bready(d_bready),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_awready(s_awready), .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .grant(grant),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid),
    .d_awready(d_awready), .d_wready(d_wready), .d_bresp(d_bresp), .d_bvalid(d_bvalid)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [63:0] exp_i, exp_d, obs_i, obs_d;
    exp_i = '0;
    exp_d = '0;
    if (owner == 1) exp_i = {28'd0, s_arready, s_rdata, s_rresp, s_rvalid};
    if (owner == 2) exp_d = {23'd0, s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid};
    obs_i = {28'd0, i_arready, i_rdata, i_rresp, i_rvalid};
    obs_d = {23'd0, d_arready, d_rdata, d_rresp, d_rvalid, d_awready, d_wready, d_bresp, d_bvalid};
    chk("grant", {62'd0, grant}, 64'(owner));
    chk("ifu_outputs", obs_i, exp_i);
    chk("lsu_outputs", obs_d, exp_d);
  endtask

  // Applies the arbitration rules to the inputs seen at this clock edge.
  task automatic model_edge();
    bit want_i, want_d, done;
    if (!rstn) begin
      owner = 0; last_served = 2; lsu_write = 1'b0;
    end else if (owner == 0) begin
      want_i = i_arvalid;
      want_d = d_arvalid | d_awvalid;
      if (want_i && want_d) owner = (last_served == 2) ? 1 : 2;
      else if (want_i)      owner = 1;
      else if (want_d)      owner = 2;
      if (owner != 0) last_served = owner;
      if (owner == 2) lsu_write = d_awvalid;
    end else begin
      if (owner == 1) done = s_rvalid && i_rready;
      else            done = lsu_write ? (s_bvalid && d_bready) : (s_rvalid && d_rready);
      if (done) owner = 0;
    end
  endtask

  // Check current-cycle outputs, then advance one clock.
  task automatic cyc();
    #2;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    i_arvalid = 0; i_rready = 0; d_arvalid = 0; d_rready = 0; d_awvalid = 0;
    d_wvalid = 0; d_bready = 0; s_arready = 0; s_rdata = '0; s_rresp = '0;
    s_rvalid = 0; s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
  endtask

  initial begin
    logic [31:0] word;
    int exp_g;
    clear_inputs();
    rstn = 0;
    @(posedge clk); model_edge(); #1;
    cyc();
    chk("reset_grant", {62'd0, grant}, 64'd0);
    rstn = 1;

    // IFU-only read: grant at cycle 1, data at cycle 3, released at cycle 4
    i_arvalid = 1; i_rready = 1;
    cyc();
    chk("ifu_only_grant", {62'd0, grant}, 64'd1);
    i_arvalid = 0;
    cyc(); cyc();
    word = $urandom; s_rdata = word; s_rresp = 2'b10; s_rvalid = 1; s_arready = 1;
    #2;
    chk("ifu_rdata", {32'd0, i_rdata}, {32'd0, word});
    chk("ifu_rvalid", {63'd0, i_rvalid}, 64'd1);
    cyc();
    chk("ifu_release", {62'd0, grant}, 64'd0);
    clear_inputs();

    // Contention right after reset: IFU, one empty cycle, then LSU
    rstn = 0; cyc(); rstn = 1;
    i_arvalid = 1; d_arvalid = 1; i_rready = 1; d_rready = 1;
    cyc();
    chk("contend_first", {62'd0, grant}, 64'd1);
    s_rvalid = 1;
    cyc();
    chk("contend_gap", {62'd0, grant}, 64'd0);
    s_rvalid = 0; i_arvalid = 0;
    cyc();
    chk("contend_second", {62'd0, grant}, 64'd2);
    s_rvalid = 1;
    cyc();
    chk("contend_done", {62'd0, grant}, 64'd0);

    // Both masters hammering: strict alternation with an idle cycle between grants
    i_arvalid = 1; d_arvalid = 1;
    for (int k = 0; k < 12; k++) begin
      s_rdata = $urandom;
      cyc();
      exp_g = (k % 2 == 1) ? 0 : (((k / 2) % 2 == 0) ? 1 : 2);
      chk("alternate", {62'd0, grant}, 64'(exp_g));
    end
    clear_inputs();

    // LSU read+write together is a write: read-valid pulses must not end it
    d_arvalid = 1; d_awvalid = 1; d_rready = 1;
    cyc();
    chk("write_grant", {62'd0, grant}, 64'd2);
    d_arvalid = 0; d_awvalid = 0; s_rvalid = 1;
    cyc(); cyc();
    chk("write_hold", {62'd0, grant}, 64'd2);
    s_rvalid = 0; s_bvalid = 1; s_bresp = 2'b01; d_bready = 1;
    #2;
    chk("write_bvalid", {63'd0, d_bvalid}, 64'd1);
    cyc();
    chk("write_done", {62'd0, grant}, 64'd0);
    clear_inputs();

    // Reset in the middle of an LSU write; pending IFU wins afterwards
    d_awvalid = 1;
    cyc();
    d_awvalid = 0; i_arvalid = 1; d_arvalid = 1;
    cyc();
    chk("pre_reset_hold", {62'd0, grant}, 64'd2);
    rstn = 0;
    cyc();
    chk("reset_mid_grant", {62'd0, grant}, 64'd0);
    s_bvalid = 1; s_arready = 1;
    #2;
    chk("reset_mid_douts", {62'd0, d_bvalid, d_arready}, 64'd0);
    s_bvalid = 0; s_arready = 0;
    rstn = 1;
    cyc();
    chk("after_reset_ifu", {62'd0, grant}, 64'd1);

    // Write response noise while IFU owns the port
    i_arvalid = 0; d_arvalid = 0;
    s_bvalid = 1; s_bresp = 2'b11; s_rdata = 32'hCAFE_F00D; s_rvalid = 0;
    #2;
    chk("stray_bvalid", {63'd0, d_bvalid}, 64'd0);
    chk("ifu_unaffected", {32'd0, i_rdata}, 64'hCAFE_F00D);
    cyc(); cyc();
    clear_inputs();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      rstn      = ($urandom_range(0, 63) != 0);
      i_arvalid = ($urandom_range(0, 2) != 0);
      d_arvalid = ($urandom_range(0, 2) == 0);
      d_awvalid = ($urandom_range(0, 3) == 0);
      d_wvalid  = $urandom_range(0, 1);
      i_rready  = $urandom_range(0, 1);
      d_rready  = $urandom_range(0, 1);
      d_bready  = $urandom_range(0, 1);
      s_arready = $urandom_range(0, 1);
      s_rdata   = $urandom;
      s_rresp   = 2'($urandom_range(0, 3));
      s_rvalid  = ($urandom_range(0, 2) == 0);
      s_awready = $urandom_range(0, 1);
      s_wready  = $urandom_range(0, 1);
      s_bresp   = 2'($urandom_range(0, 3));
      s_bvalid  = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
